// File: rtl/ifid_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl_if
//   Bundle of the hazard-controller signals that flow between the pipeline
//   datapath and the IF/ID hazard/sequencing controller.
//
//   master : the pipeline side. It drives IF/ID, ID/EX and EX/MEM status, the
//            branch resolution and the memory stalls, and receives the
//            enables, flushes and halt status.
//   slave  : the controller side (ifid_hazard_ctrl).
//
//   Parameters
//     REG_BITS     register index width
//     STALL_CNT_W  width of the stall-cycle counter
// ---------------------------------------------------------------------------
interface ifid_hazard_ctrl_if #(
    parameter int REG_BITS    = 3,
    parameter int STALL_CNT_W = 16
);
    // IF/ID stage status
    logic                   ifIdValidIns;
    logic                   ifIdRsValid;
    logic                   ifIdRtValid;
    logic [REG_BITS-1:0]    ifIdRs;
    logic [REG_BITS-1:0]    ifIdRt;
    logic                   ifIdHalt;

    // Older in-flight writers
    logic                   idExWriteRegValid;
    logic [REG_BITS-1:0]    idExWriteReg;
    logic                   exMemWriteRegValid;
    logic [REG_BITS-1:0]    exMemWriteReg;

    // Redirect and memory status
    logic                   exBranchTaken;
    logic                   imemStall;
    logic                   dmemStall;

    // Controller outputs
    logic                   writePc;
    logic                   writeIfId;
    logic                   flushIf;
    logic                   flushIdEx;
    logic                   freezeBack;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stallCount;

    modport master (
        output ifIdValidIns, ifIdRsValid, ifIdRtValid, ifIdRs, ifIdRt, ifIdHalt,
        output idExWriteRegValid, idExWriteReg, exMemWriteRegValid, exMemWriteReg,
        output exBranchTaken, imemStall, dmemStall,
        input  writePc, writeIfId, flushIf, flushIdEx, freezeBack, halted, stallCount
    );

    modport slave (
        input  ifIdValidIns, ifIdRsValid, ifIdRtValid, ifIdRs, ifIdRt, ifIdHalt,
        input  idExWriteRegValid, idExWriteReg, exMemWriteRegValid, exMemWriteReg,
        input  exBranchTaken, imemStall, dmemStall,
        output writePc, writeIfId, flushIf, flushIdEx, freezeBack, halted, stallCount
    );
endinterface

// File: rtl/ifid_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl
//   Hazard and sequencing controller for the PC and the IF/ID pipeline
//   register of an in-order pipeline without forwarding. It produces the PC
//   and IF/ID write enables, the IF/ID and ID/EX flushes and the back-end
//   freeze from RAW hazards, taken branches and instruction/data memory
//   stalls. It also sequences the HALT drain (RUN -> DRAIN -> HALTED) and
//   keeps a saturating count of stall cycles since reset.
//
//   The register file writes before it reads, so the MEM/WB writer is never
//   a hazard source; only ID/EX and EX/MEM destinations are compared.
//
//   Ports
//     clk   in   system clock, all state on the rising edge
//     rst   in   synchronous, active-high reset
//     bus   slave modport of ifid_hazard_ctrl_if:
//             in : ifIdValidIns, ifIdRsValid, ifIdRtValid, ifIdRs, ifIdRt,
//                  ifIdHalt, idExWriteRegValid, idExWriteReg,
//                  exMemWriteRegValid, exMemWriteReg, exBranchTaken,
//                  imemStall, dmemStall
//             out: writePc, writeIfId, flushIf, flushIdEx, freezeBack,
//                  halted, stallCount
//
//   Parameters
//     REG_BITS     register index width (must match the interface)
//     DRAIN_CYC    cycles given to older instructions to retire once HALT
//                  is held in ID (>= 1)
//     STALL_CNT_W  stall counter width (must match the interface)
//
//   All control outputs are combinational on the current inputs and state;
//   state and counters change on the rising clock edge.
// ---------------------------------------------------------------------------
module ifid_hazard_ctrl #(
    parameter int REG_BITS    = 3,
    parameter int DRAIN_CYC   = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    ifid_hazard_ctrl_if.slave bus
);

    localparam int DRAIN_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Saturating increment: the counter sticks at all-ones rather than wrap.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(
        input logic [STALL_CNT_W-1:0] v
    );
        if (&v) begin
            return v;
        end
        return v + STALL_CNT_W'(1);
    endfunction

    // Registered state
    state_t                 r_state;
    logic [DRAIN_W-1:0]     r_drain_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Next-state and output wires
    state_t                 w_next_state;
    logic [DRAIN_W-1:0]     w_drain_nxt;
    logic                   w_count;
    logic                   w_write_pc;
    logic                   w_write_ifid;
    logic                   w_flush_if;
    logic                   w_flush_idex;
    logic                   w_freeze_back;
    logic                   w_halted;

    // Hazard detection
    logic w_hit_rs;
    logic w_hit_rt;
    logic w_raw_hazard;
    logic w_halt_in_id;

    // A source register conflicts with an older writer only if that writer
    // actually writes a register; an invalid writer never matches, even when
    // its (don't-care) index happens to equal the source index.
    always_comb begin
        w_hit_rs = (bus.idExWriteRegValid  && (bus.idExWriteReg  == bus.ifIdRs)) ||
                   (bus.exMemWriteRegValid && (bus.exMemWriteReg == bus.ifIdRs));
        w_hit_rt = (bus.idExWriteRegValid  && (bus.idExWriteReg  == bus.ifIdRt)) ||
                   (bus.exMemWriteRegValid && (bus.exMemWriteReg == bus.ifIdRt));
        w_raw_hazard = bus.ifIdValidIns &&
                       ((bus.ifIdRsValid && w_hit_rs) || (bus.ifIdRtValid && w_hit_rt));
        w_halt_in_id = bus.ifIdValidIns && bus.ifIdHalt;
    end

    // Next-state and output decode
    always_comb begin
        w_next_state  = r_state;
        w_drain_nxt   = r_drain_cnt;
        w_count       = 1'b0;
        w_write_pc    = 1'b0;
        w_write_ifid  = 1'b0;
        w_flush_if    = 1'b0;
        w_flush_idex  = 1'b0;
        w_freeze_back = 1'b0;
        w_halted      = 1'b0;

        if (rst) begin
            // Squash whatever is entering IF/ID and ID/EX while reset is
            // asserted; the back end is allowed to clock so it empties out.
            w_flush_if   = 1'b1;
            w_flush_idex = 1'b1;
            w_next_state = ST_RUN;
            w_drain_nxt  = '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.dmemStall) begin
                        // Whole pipe holds still; nothing is flushed.
                        w_freeze_back = 1'b1;
                        w_count       = 1'b1;
                    end else if (bus.exBranchTaken) begin
                        // Redirect: load the target and kill the two younger
                        // wrong-path instructions. Not a stall cycle.
                        w_write_pc   = 1'b1;
                        w_write_ifid = 1'b1;
                        w_flush_if   = 1'b1;
                        w_flush_idex = 1'b1;
                    end else if (w_raw_hazard) begin
                        // Hold PC and IF/ID, insert a bubble behind the
                        // producer.
                        w_flush_idex = 1'b1;
                        w_count      = 1'b1;
                    end else if (bus.imemStall) begin
                        // IF/ID advances so ID proceeds, but receives a bubble
                        // while the fetch is outstanding.
                        w_write_ifid = 1'b1;
                        w_flush_if   = 1'b1;
                        w_count      = 1'b1;
                    end else if (w_halt_in_id) begin
                        // Freeze HALT in IF/ID and start draining older work.
                        w_next_state = ST_DRAIN;
                        w_drain_nxt  = DRAIN_W'(DRAIN_CYC);
                    end else begin
                        w_write_pc   = 1'b1;
                        w_write_ifid = 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (bus.dmemStall) begin
                        // Older instructions cannot retire; drain time does
                        // not elapse.
                        w_freeze_back = 1'b1;
                        w_count       = 1'b1;
                    end else if (bus.exBranchTaken) begin
                        // The held HALT was on the wrong path: redirect and
                        // resume, even if this was the last drain cycle.
                        w_write_pc   = 1'b1;
                        w_write_ifid = 1'b1;
                        w_flush_if   = 1'b1;
                        w_flush_idex = 1'b1;
                        w_next_state = ST_RUN;
                        w_drain_nxt  = '0;
                    end else begin
                        // HALT stays in IF/ID; bubbles go down behind it.
                        w_flush_idex = 1'b1;
                        w_drain_nxt  = r_drain_cnt - DRAIN_W'(1);
                        if (r_drain_cnt <= DRAIN_W'(1)) begin
                            w_next_state = ST_HALTED;
                        end
                    end
                end

                ST_HALTED: begin
                    w_freeze_back = 1'b1;
                    w_halted      = 1'b1;
                end

                default: begin
                    // Unreachable encoding: recover to RUN.
                    w_next_state = ST_RUN;
                    w_drain_nxt  = '0;
                end
            endcase
        end
    end

    // State, drain counter and stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_nxt;
            if (w_count) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign bus.writePc    = w_write_pc;
    assign bus.writeIfId  = w_write_ifid;
    assign bus.flushIf    = w_flush_if;
    assign bus.flushIdEx  = w_flush_idex;
    assign bus.freezeBack = w_freeze_back;
    assign bus.halted     = w_halted;
    assign bus.stallCount = r_stall_cnt;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifid_hazard_ctrl
//   Directed bench for ifid_hazard_ctrl. The stall counter is built 5 bits
//   wide here so saturation is reachable in a short run.
//   Control vector order: {writePc, writeIfId, flushIf, flushIdEx,
//   freezeBack, halted}.
// ---------------------------------------------------------------------------
module tb_ifid_hazard_ctrl;

    localparam int REG_BITS    = 3;
    localparam int DRAIN_CYC   = 3;
    localparam int STALL_CNT_W = 5;

    // Expected control vectors {writePc, writeIfId, flushIf, flushIdEx, freezeBack, halted}
    localparam logic [5:0] C_RST    = 6'b001100;
    localparam logic [5:0] C_IDLE   = 6'b110000;
    localparam logic [5:0] C_RAW    = 6'b000100;
    localparam logic [5:0] C_BRANCH = 6'b111100;
    localparam logic [5:0] C_IMEM   = 6'b011000;
    localparam logic [5:0] C_DMEM   = 6'b000010;
    localparam logic [5:0] C_HTRANS = 6'b000000;
    localparam logic [5:0] C_DRAIN  = 6'b000100;
    localparam logic [5:0] C_HALTED = 6'b000011;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ifid_hazard_ctrl_if #(.REG_BITS(REG_BITS), .STALL_CNT_W(STALL_CNT_W)) bus ();

    ifid_hazard_ctrl #(
        .REG_BITS   (REG_BITS),
        .DRAIN_CYC  (DRAIN_CYC),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [5:0] ctl;
    assign ctl = {bus.writePc, bus.writeIfId, bus.flushIf, bus.flushIdEx,
                  bus.freezeBack, bus.halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.ifIdValidIns       = 1'b0;
        bus.ifIdRsValid        = 1'b0;
        bus.ifIdRtValid        = 1'b0;
        bus.ifIdRs             = '0;
        bus.ifIdRt             = '0;
        bus.ifIdHalt           = 1'b0;
        bus.idExWriteRegValid  = 1'b0;
        bus.idExWriteReg       = '0;
        bus.exMemWriteRegValid = 1'b0;
        bus.exMemWriteReg      = '0;
        bus.exBranchTaken      = 1'b0;
        bus.imemStall          = 1'b0;
        bus.dmemStall          = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RST) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", ctl, C_RST);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_fail++;
            $display("FAIL idle_ctl: got %b expected %b", ctl, C_IDLE);
        end
        n_checks++;
        if (bus.stallCount !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", bus.stallCount);
        end
    endtask

    task automatic test_raw;
        do_reset();
        // Rs=3 against ID/EX writer of r3
        bus.ifIdValidIns      = 1'b1;
        bus.ifIdRsValid       = 1'b1;
        bus.ifIdRs            = 3'd3;
        bus.idExWriteRegValid = 1'b1;
        bus.idExWriteReg      = 3'd3;
        #1;
        n_checks++;
        if (ctl !== C_RAW) begin
            n_fail++;
            $display("FAIL raw_idex_ctl: got %b expected %b", ctl, C_RAW);
        end
        tick();
        // Producer moved to EX/MEM
        bus.idExWriteRegValid  = 1'b0;
        bus.exMemWriteRegValid = 1'b1;
        bus.exMemWriteReg      = 3'd3;
        #1;
        n_checks++;
        if (ctl !== C_RAW) begin
            n_fail++;
            $display("FAIL raw_exmem_ctl: got %b expected %b", ctl, C_RAW);
        end
        tick();
        bus.exMemWriteRegValid = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_fail++;
            $display("FAIL raw_clear_ctl: got %b expected %b", ctl, C_IDLE);
        end
        n_checks++;
        if (bus.stallCount !== 5'd2) begin
            n_fail++;
            $display("FAIL raw_count: got %0d expected 2", bus.stallCount);
        end
        // Rt=5 against EX/MEM writer of r5
        bus.ifIdRsValid        = 1'b0;
        bus.ifIdRtValid        = 1'b1;
        bus.ifIdRt             = 3'd5;
        bus.exMemWriteRegValid = 1'b1;
        bus.exMemWriteReg      = 3'd5;
        #1;
        n_checks++;
        if (ctl !== C_RAW) begin
            n_fail++;
            $display("FAIL raw_rt_ctl: got %b expected %b", ctl, C_RAW);
        end
        tick();
        // Index match but Rs not read, Rt differs, writer index invalid-only
        bus.ifIdRsValid        = 1'b0;
        bus.ifIdRs             = 3'd6;
        bus.ifIdRt             = 3'd1;
        bus.idExWriteRegValid  = 1'b1;
        bus.idExWriteReg       = 3'd6;
        bus.exMemWriteRegValid = 1'b0;
        bus.exMemWriteReg      = 3'd1;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_fail++;
            $display("FAIL raw_nomatch_ctl: got %b expected %b", ctl, C_IDLE);
        end
        // Matching index but instruction not valid
        bus.ifIdRsValid  = 1'b1;
        bus.ifIdValidIns = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_fail++;
            $display("FAIL raw_invalid_ctl: got %b expected %b", ctl, C_IDLE);
        end
        tick();
        n_checks++;
        if (bus.stallCount !== 5'd3) begin
            n_fail++;
            $display("FAIL raw_rt_count: got %0d expected 3", bus.stallCount);
        end
    endtask

    task automatic test_branch_priority;
        do_reset();
        // RAW hazard together with a taken branch: branch wins
        bus.ifIdValidIns      = 1'b1;
        bus.ifIdRsValid       = 1'b1;
        bus.ifIdRs            = 3'd2;
        bus.idExWriteRegValid = 1'b1;
        bus.idExWriteReg      = 3'd2;
        bus.exBranchTaken     = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_BRANCH) begin
            n_fail++;
            $display("FAIL branch_raw_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        tick();
        n_checks++;
        if (bus.stallCount !== 5'd0) begin
            n_fail++;
            $display("FAIL branch_count: got %0d expected 0", bus.stallCount);
        end
        // Branch with imem stall: branch still wins
        clear_inputs();
        bus.exBranchTaken = 1'b1;
        bus.imemStall     = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_BRANCH) begin
            n_fail++;
            $display("FAIL branch_imem_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        // dmem stall over branch
        bus.dmemStall = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_DMEM) begin
            n_fail++;
            $display("FAIL dmem_over_branch_ctl: got %b expected %b", ctl, C_DMEM);
        end
        tick();
        // imem stall alone
        clear_inputs();
        bus.imemStall = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_IMEM) begin
            n_fail++;
            $display("FAIL imem_ctl: got %b expected %b", ctl, C_IMEM);
        end
        tick();
        n_checks++;
        if (bus.stallCount !== 5'd2) begin
            n_fail++;
            $display("FAIL imem_count: got %0d expected 2", bus.stallCount);
        end
    endtask

    task automatic test_dmem;
        do_reset();
        bus.dmemStall = 1'b1;
        bus.imemStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_DMEM) begin
                n_fail++;
                $display("FAIL dmem_ctl[%0d]: got %b expected %b", i, ctl, C_DMEM);
            end
            tick();
        end
        clear_inputs();
        #1;
        n_checks++;
        if (bus.stallCount !== 5'd4) begin
            n_fail++;
            $display("FAIL dmem_count: got %0d expected 4", bus.stallCount);
        end
    endtask

    task automatic test_halt;
        do_reset();
        bus.ifIdValidIns = 1'b1;
        bus.ifIdHalt     = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_HTRANS) begin
            n_fail++;
            $display("FAIL halt_enter_ctl: got %b expected %b", ctl, C_HTRANS);
        end
        tick();
        for (int i = 0; i < DRAIN_CYC; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_DRAIN) begin
                n_fail++;
                $display("FAIL drain_ctl[%0d]: got %b expected %b", i, ctl, C_DRAIN);
            end
            tick();
        end
        n_checks++;
        if (ctl !== C_HALTED) begin
            n_fail++;
            $display("FAIL halted_ctl: got %b expected %b", ctl, C_HALTED);
        end
        // Activity while halted must not enable anything
        bus.ifIdHalt      = 1'b0;
        bus.exBranchTaken = 1'b1;
        bus.imemStall     = 1'b1;
        tick();
        bus.exBranchTaken = 1'b0;
        bus.dmemStall     = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_HALTED) begin
            n_fail++;
            $display("FAIL halted_hold_ctl: got %b expected %b", ctl, C_HALTED);
        end
        n_checks++;
        if (bus.stallCount !== 5'd0) begin
            n_fail++;
            $display("FAIL halted_count: got %0d expected 0", bus.stallCount);
        end
        // Reset out of HALTED
        clear_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RST) begin
            n_fail++;
            $display("FAIL halted_rst_ctl: got %b expected %b", ctl, C_RST);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_IDLE) begin
            n_fail++;
            $display("FAIL after_halt_rst_ctl: got %b expected %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_drain_dmem;
        do_reset();
        bus.ifIdValidIns = 1'b1;
        bus.ifIdHalt     = 1'b1;
        tick();
        // drain 3 -> 2
        tick();
        // dmem stall holds the drain counter
        bus.dmemStall = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_DMEM) begin
            n_fail++;
            $display("FAIL drain_dmem_ctl: got %b expected %b", ctl, C_DMEM);
        end
        tick();
        bus.dmemStall = 1'b0;
        // two more drain cycles still required
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_DRAIN) begin
                n_fail++;
                $display("FAIL drain_resume_ctl[%0d]: got %b expected %b", i, ctl, C_DRAIN);
            end
            tick();
        end
        n_checks++;
        if (ctl !== C_HALTED) begin
            n_fail++;
            $display("FAIL drain_dmem_halted_ctl: got %b expected %b", ctl, C_HALTED);
        end
        n_checks++;
        if (bus.stallCount !== 5'd1) begin
            n_fail++;
            $display("FAIL drain_dmem_count: got %0d expected 1", bus.stallCount);
        end
    endtask

    task automatic test_halt_branch;
        do_reset();
        bus.ifIdValidIns = 1'b1;
        bus.ifIdHalt     = 1'b1;
        tick();
        // first DRAIN cycle
        tick();
        // second DRAIN cycle: wrong-path HALT
        bus.exBranchTaken = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_BRANCH) begin
            n_fail++;
            $display("FAIL drain_branch_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_IDLE) begin
                n_fail++;
                $display("FAIL drain_branch_run_ctl[%0d]: got %b expected %b", i, ctl, C_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain;
        do_reset();
        bus.ifIdValidIns = 1'b1;
        bus.ifIdHalt     = 1'b1;
        tick();
        clear_inputs();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RST) begin
            n_fail++;
            $display("FAIL drain_rst_ctl: got %b expected %b", ctl, C_RST);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ctl !== C_IDLE) begin
                n_fail++;
                $display("FAIL drain_rst_run_ctl[%0d]: got %b expected %b", i, ctl, C_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_saturation;
        do_reset();
        bus.dmemStall = 1'b1;
        repeat (30) tick();
        n_checks++;
        if (bus.stallCount !== 5'd30) begin
            n_fail++;
            $display("FAIL sat_count_30: got %0d expected 30", bus.stallCount);
        end
        tick();
        n_checks++;
        if (bus.stallCount !== 5'd31) begin
            n_fail++;
            $display("FAIL sat_count_31: got %0d expected 31", bus.stallCount);
        end
        repeat (10) tick();
        n_checks++;
        if (bus.stallCount !== 5'd31) begin
            n_fail++;
            $display("FAIL sat_count_hold: got %0d expected 31", bus.stallCount);
        end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_raw();
        test_branch_priority();
        test_dmem();
        test_halt();
        test_drain_dmem();
        test_halt_branch();
        test_reset_mid_drain();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
